// File: rtl/vdp2_vram_write_drain_if.sv
// ---------------------------------------------------------------------------
// vdp2_vram_write_drain_if
// Bundles the write-FIFO head, per-bank slot grants and the VRAM write
// request/acknowledge bus seen by the VDP2 CPU write drain.
//   master : the drain itself (pops the FIFO, drives the VRAM write request)
//   slave  : the surrounding FIFO / arbiter / VRAM controller side
// ---------------------------------------------------------------------------
interface vdp2_vram_write_drain_if;
  logic [35:0] fifo_q;      // {be_hi, be_lo, bank[1:0], addr[15:0], data[15:0]}
  logic        fifo_empty;
  logic        fifo_rdreq;
  logic [3:0]  slot_free;   // bit i = CPU slot granted on bank i this cycle
  logic [1:0]  bank_split;  // [0] VRAM-A split, [1] VRAM-B split
  logic        vram_req;
  logic [17:0] vram_a;      // {bank, word address}
  logic [15:0] vram_d;
  logic [1:0]  vram_we;
  logic        vram_ack;
  logic        busy;
  logic        err;

  modport master (
    input  fifo_q, fifo_empty, slot_free, bank_split, vram_ack,
    output fifo_rdreq, vram_req, vram_a, vram_d, vram_we, busy, err
  );

  modport slave (
    output fifo_q, fifo_empty, slot_free, bank_split, vram_ack,
    input  fifo_rdreq, vram_req, vram_a, vram_d, vram_we, busy, err
  );
endinterface

// File: rtl/vdp2_vram_write_drain.sv
// ---------------------------------------------------------------------------
// vdp2_vram_write_drain
// Drain side of the VDP2 CPU write FIFO. Pops one entry at a time into a
// holding register, waits for a CPU slot on the target VRAM bank and issues
// the write with a req/ack handshake. Writes leave in FIFO order.
//
// Optional feature macro: VDP2_DRAIN_WDT_EN
//   defined   : an ISSUE-state watchdog abandons a write that is not
//               acknowledged within WDT_CYCLES cycles and sets sticky ERR.
//   undefined : ISSUE waits indefinitely for VRAM_ACK, ERR is tied low.
// ---------------------------------------------------------------------------
module vdp2_vram_write_drain #(
  parameter int unsigned WDT_CYCLES = 255
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  vdp2_vram_write_drain_if.master       bus
);

  // The watchdog counter is 8 bits wide; reject unusable limits at build time.
  if ((WDT_CYCLES < 1) || (WDT_CYCLES > 255)) begin : g_wdt_range_bad
    $error("vdp2_vram_write_drain: WDT_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SLOT = 2'd1,
    ST_ISSUE     = 2'd2
  } state_e;

  // Effective CPU-slot grant for a bank: an unsplit VRAM half answers to the
  // slot bit of its first sub-bank, a split half to its own bit.
  function automatic logic slot_grant(input logic [1:0] bank,
                                      input logic [1:0] split,
                                      input logic [3:0] free);
    logic grant;
    grant = 1'b0;
    case (bank[1])
      1'b0:    grant = split[0] ? free[bank] : free[0];
      1'b1:    grant = split[1] ? free[bank] : free[2];
      default: grant = 1'b0;
    endcase
    return grant;
  endfunction

  state_e      state_q, state_d;
  logic        rdreq_q, rdreq_d;
  logic        req_q,   req_d;
  logic [17:0] hold_a_q, hold_a_d;
  logic [15:0] hold_d_q, hold_d_d;
  logic [1:0]  hold_we_q, hold_we_d;

  logic        can_latch_s;
  logic        latch_en_s;
  logic        entry_be_zero_s;
  logic        grant_s;

`ifdef VDP2_DRAIN_WDT_EN
  localparam logic [7:0] WDT_LIMIT = 8'(WDT_CYCLES);
  logic [7:0]  wdt_q, wdt_d;
  logic        err_q, err_d;
`endif

  // The FIFO head only advances on the edge after a pop, so a pop in flight
  // blocks the next latch.
  assign can_latch_s     = ~bus.fifo_empty & ~rdreq_q;
  assign entry_be_zero_s = (bus.fifo_q[35:34] == 2'b00);
  assign grant_s         = slot_grant(hold_a_q[17:16], bus.bank_split, bus.slot_free);

  // Next-state, pop strobe, request and holding-register control.
  always_comb begin
    state_d    = state_q;
    rdreq_d    = 1'b0;
    req_d      = req_q;
    latch_en_s = 1'b0;
`ifdef VDP2_DRAIN_WDT_EN
    wdt_d      = wdt_q;
    err_d      = err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        req_d = 1'b0;
        if (can_latch_s) begin
          latch_en_s = 1'b1;
          rdreq_d    = 1'b1;
          // Entries with no byte enabled are popped and dropped here.
          state_d    = entry_be_zero_s ? ST_IDLE : ST_WAIT_SLOT;
        end else begin
          state_d    = ST_IDLE;
        end
      end

      ST_WAIT_SLOT: begin
        if (grant_s) begin
          state_d = ST_ISSUE;
          req_d   = 1'b1;
`ifdef VDP2_DRAIN_WDT_EN
          wdt_d   = 8'd0;
`endif
        end else begin
          state_d = ST_WAIT_SLOT;
        end
      end

      ST_ISSUE: begin
        if (bus.vram_ack) begin
          req_d = 1'b0;
          // Back-to-back: pick up the next entry in the acknowledge cycle.
          if (can_latch_s) begin
            latch_en_s = 1'b1;
            rdreq_d    = 1'b1;
            state_d    = entry_be_zero_s ? ST_IDLE : ST_WAIT_SLOT;
          end else begin
            state_d    = ST_IDLE;
          end
        end else begin
`ifdef VDP2_DRAIN_WDT_EN
          wdt_d = wdt_q + 8'd1;
          if ((wdt_q + 8'd1) == WDT_LIMIT) begin
            // Controller never answered: abandon this write and flag it.
            req_d   = 1'b0;
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ISSUE;
          end
`else
          state_d = ST_ISSUE;
`endif
        end
      end

      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // Holding register load from the FIFO head.
  always_comb begin
    hold_a_d  = hold_a_q;
    hold_d_d  = hold_d_q;
    hold_we_d = hold_we_q;
    if (latch_en_s) begin
      hold_we_d = bus.fifo_q[35:34];
      hold_a_d  = bus.fifo_q[33:16];
      hold_d_d  = bus.fifo_q[15:0];
    end else begin
      hold_we_d = hold_we_q;
    end
  end

  // State and output registers; synchronous active-low reset drops any held write.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      rdreq_q   <= 1'b0;
      req_q     <= 1'b0;
      hold_a_q  <= 18'd0;
      hold_d_q  <= 16'd0;
      hold_we_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      rdreq_q   <= rdreq_d;
      req_q     <= req_d;
      hold_a_q  <= hold_a_d;
      hold_d_q  <= hold_d_d;
      hold_we_q <= hold_we_d;
    end
  end

`ifdef VDP2_DRAIN_WDT_EN
  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wdt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      wdt_q <= wdt_d;
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.fifo_rdreq = rdreq_q;
  assign bus.vram_req   = req_q;
  assign bus.vram_a     = hold_a_q;
  assign bus.vram_d     = hold_d_q;
  assign bus.vram_we    = hold_we_q;
  // Reads are held off while anything is queued, held or in flight.
  assign bus.busy       = ~bus.fifo_empty | (state_q != ST_IDLE) | rdreq_q;

endmodule

// File: tb/tb_vdp2_vram_write_drain.sv
// ---------------------------------------------------------------------------
// tb_vdp2_vram_write_drain
// Directed bench: a queue models the write FIFO, a second queue holds the
// writes expected on the VRAM bus in order. Outputs are sampled on the
// falling clock edge; VRAM_ACK is driven there so it lands in the same cycle
// as the request it answers.
// ---------------------------------------------------------------------------
module tb_vdp2_vram_write_drain;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  vdp2_vram_write_drain_if bus ();

  vdp2_vram_write_drain #(.WDT_CYCLES(10)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [35:0] fifo_mdl[$];
  logic [35:0] exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_n    = 0;
  int n_rdreq, n_consec, n_req_cyc, n_acc, first_req_cyc, last_ack_cyc;
  int ack_mode = 0;   // 0: never ack, 1: ack each request, 2: ack held high
  int start_cyc;
  logic        prev_rd, prev_req;
  logic [35:0] prev_bus;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    if (fifo_mdl.size() > 0) begin
      bus.fifo_q     = fifo_mdl[0];
      bus.fifo_empty = 1'b0;
    end else begin
      bus.fifo_q     = 36'h0;
      bus.fifo_empty = 1'b1;
    end
  endtask

  task automatic push(input logic [35:0] e);
    fifo_mdl.push_back(e);
    if (e[35:34] != 2'b00) exp_q.push_back(e);
    drive_fifo();
  endtask

  task automatic reset_cnt();
    n_rdreq = 0; n_consec = 0; n_req_cyc = 0; n_acc = 0;
    first_req_cyc = -1; last_ack_cyc = -1;
  endtask

  // One clock: sample at the falling edge, score, then drive next inputs.
  task automatic cyc();
    logic [35:0] e;
    @(negedge clk);
    cyc_n++;
    if (bus.fifo_rdreq === 1'b1) begin
      n_rdreq++;
      if (prev_rd) n_consec++;
      if (fifo_mdl.size() > 0) void'(fifo_mdl.pop_front());
    end
    prev_rd = (bus.fifo_rdreq === 1'b1);
    if (bus.vram_req === 1'b1) begin
      n_req_cyc++;
      if (first_req_cyc < 0) first_req_cyc = cyc_n;
      if (prev_req) chk("hold_stable", {bus.vram_we, bus.vram_a, bus.vram_d}, prev_bus);
    end
    prev_req = (bus.vram_req === 1'b1);
    prev_bus = {bus.vram_we, bus.vram_a, bus.vram_d};
    case (ack_mode)
      0:       bus.vram_ack = 1'b0;
      1:       bus.vram_ack = (bus.vram_req === 1'b1);
      default: bus.vram_ack = 1'b1;
    endcase
    if ((bus.vram_req === 1'b1) && bus.vram_ack) begin
      n_acc++;
      last_ack_cyc = cyc_n;
      chk("write_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("vram_a", bus.vram_a, e[33:16]);
        chk("vram_d", bus.vram_d, e[15:0]);
        chk("vram_we", bus.vram_we, e[35:34]);
      end
    end
    drive_fifo();
  endtask

  task automatic run_idle(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      cyc();
      if ((bus.busy === 1'b0) && (fifo_mdl.size() == 0)) break;
    end
    chk(tag, bus.busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    bus.fifo_q     = 36'h0;
    bus.fifo_empty = 1'b1;
    bus.slot_free  = 4'h0;
    bus.bank_split = 2'b00;
    bus.vram_ack   = 1'b0;
    prev_rd = 1'b0; prev_req = 1'b0; prev_bus = 36'h0;
    reset_cnt();

    // Reset values
    rst_n = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    chk("rst_req",   bus.vram_req,   1'b0);
    chk("rst_a",     bus.vram_a,     18'h0);
    chk("rst_d",     bus.vram_d,     16'h0);
    chk("rst_we",    bus.vram_we,    2'b00);
    chk("rst_rdreq", bus.fifo_rdreq, 1'b0);
    chk("rst_err",   bus.err,        1'b0);
    chk("rst_busy",  bus.busy,       1'b0);

    // Single write, slot free, ack on the request cycle
    bus.slot_free = 4'hF;
    ack_mode = 1;
    reset_cnt();
    start_cyc = cyc_n;
    push({2'b11, 2'd2, 16'h1234, 16'hBEEF});
    #1 chk("busy_follows_empty", bus.busy, 1'b1);
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (n_acc > 0) break;
    end
    chk("t1_latency", first_req_cyc - start_cyc, 2);
    chk("t1_busy_ack", bus.busy, 1'b1);
    cyc();
    chk("t1_busy_drop", bus.busy, 1'b0);
    chk("t1_req_drop", bus.vram_req, 1'b0);
    chk("t1_rdreq_cnt", n_rdreq, 1);
    chk("t1_acc_cnt", n_acc, 1);

    // Slot gating, unsplit VRAM-A: bank A1 waits for SLOT_FREE[0]
    reset_cnt();
    bus.slot_free  = 4'b0010;
    bus.bank_split = 2'b00;
    push({2'b11, 2'd1, 16'h0042, 16'h5A5A});
    repeat (6) cyc();
    chk("t2_no_req", n_req_cyc, 0);
    chk("t2_rdreq_cnt", n_rdreq, 1);
    bus.slot_free = 4'b0001;
    cyc();
    chk("t2_req_rise", bus.vram_req, 1'b1);
    run_idle("t2_idle", 20);
    chk("t2_acc_cnt", n_acc, 1);

    // Slot gating, split VRAM-B: bank B1 waits for its own SLOT_FREE[3]
    reset_cnt();
    bus.slot_free  = 4'b0100;
    bus.bank_split = 2'b10;
    push({2'b01, 2'd3, 16'hFFFF, 16'h00C3});
    repeat (5) cyc();
    chk("t2b_no_req", n_req_cyc, 0);
    bus.slot_free = 4'b1000;
    cyc();
    chk("t2b_req_rise", bus.vram_req, 1'b1);
    run_idle("t2b_idle", 20);
    chk("t2b_acc_cnt", n_acc, 1);

    // Discard: byte enables 00 then a valid entry
    reset_cnt();
    bus.slot_free  = 4'hF;
    bus.bank_split = 2'b00;
    push({2'b00, 2'd0, 16'h0011, 16'hDEAD});
    push({2'b10, 2'd3, 16'h0022, 16'hCAFE});
    run_idle("t3_idle", 30);
    chk("t3_rdreq_cnt", n_rdreq, 2);
    chk("t3_acc_cnt", n_acc, 1);
    chk("t3_req_cyc", n_req_cyc, 1);

    // Back-to-back: 8 entries, ACK held high
    reset_cnt();
    ack_mode = 2;
    start_cyc = cyc_n;
    for (int i = 0; i < 8; i++) begin
      push({2'b11, 2'(i), 16'(16'h0100 + i), 16'(16'hA000 + i * 273)});
    end
    run_idle("t4_idle", 40);
    chk("t4_acc_cnt", n_acc, 8);
    chk("t4_rdreq_cnt", n_rdreq, 8);
    chk("t4_rdreq_consec", n_consec, 0);
    chk("t4_within_17", (last_ack_cyc - start_cyc + 1) <= 17, 1'b1);
    ack_mode = 1;
    cyc();

    // Reset while a write is in ISSUE
    reset_cnt();
    ack_mode = 0;
    push({2'b11, 2'd0, 16'h7777, 16'h1357});
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (bus.vram_req === 1'b1) break;
    end
    chk("t5_req_up", bus.vram_req, 1'b1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("t5_req",   bus.vram_req,   1'b0);
    chk("t5_a",     bus.vram_a,     18'h0);
    chk("t5_d",     bus.vram_d,     16'h0);
    chk("t5_we",    bus.vram_we,    2'b00);
    chk("t5_err",   bus.err,        1'b0);
    chk("t5_rdreq", bus.fifo_rdreq, 1'b0);
    chk("t5_busy",  bus.busy,       1'b0);
    exp_q.delete();

`ifdef VDP2_DRAIN_WDT_EN
    // Watchdog: no ACK, request drops after 10 ISSUE cycles
    reset_cnt();
    ack_mode = 0;
    push({2'b11, 2'd1, 16'h0BAD, 16'hF00D});
    for (int i = 0; i < 40; i++) begin
      cyc();
      if ((n_req_cyc > 0) && (bus.vram_req !== 1'b1)) break;
    end
    chk("t6_req_cycles", n_req_cyc, 10);
    chk("t6_err_set", bus.err, 1'b1);
    exp_q.delete();
    repeat (3) cyc();
    chk("t6_err_sticky", bus.err, 1'b1);
    reset_cnt();
    ack_mode = 1;
    push({2'b11, 2'd2, 16'h0ACE, 16'h4242});
    run_idle("t6_idle", 20);
    chk("t6_next_acc", n_acc, 1);
    chk("t6_err_hold", bus.err, 1'b1);
`else
    chk("err_tied_low", bus.err, 1'b0);
`endif

    chk("exp_drained", exp_q.size(), 0);
    chk("fifo_drained", fifo_mdl.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
